// File: rtl/code_pkg.sv
// Shared definitions for the 3-bit <-> 7-bit code link.
// Decode tables live here so encoder and decoder stay in lockstep.
package code_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 3;

    typedef enum logic {
        RUN   = 1'b0,
        ALARM = 1'b1
    } state_t;

    // Result packing: {data, illegal}
    function automatic logic [DATA_W:0] decode_pow2(
        input logic [CODE_W-1:0] code
    );
        logic [DATA_W:0] r;
        case (code)
            7'h00:   r = {3'd0, 1'b0};
            7'h01:   r = {3'd1, 1'b0};
            7'h02:   r = {3'd2, 1'b0};
            7'h04:   r = {3'd3, 1'b0};
            7'h08:   r = {3'd4, 1'b0};
            7'h10:   r = {3'd5, 1'b0};
            7'h20:   r = {3'd6, 1'b0};
            7'h40:   r = {3'd7, 1'b0};
            default: r = {3'd0, 1'b1};
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W:0] decode_gray(
        input logic [CODE_W-1:0] code
    );
        logic [DATA_W:0] r;
        if (code[6:3] != 4'd0) begin
            r = {3'd0, 1'b1};
        end else begin
            case (code[2:0])
                3'b000:  r = {3'd0, 1'b0};
                3'b001:  r = {3'd1, 1'b0};
                3'b011:  r = {3'd2, 1'b0};
                3'b010:  r = {3'd3, 1'b0};
                3'b110:  r = {3'd4, 1'b0};
                3'b111:  r = {3'd5, 1'b0};
                3'b101:  r = {3'd6, 1'b0};
                default: r = {3'd7, 1'b0};
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/code_decode_lut.sv
// Combinational codeword lookup: 7-bit code to 3-bit value plus
// an illegal flag; table chosen at elaboration by USE_GRAY.
module code_decode_lut
    import code_pkg::*;
#(
    parameter int USE_GRAY = 0
) (
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data,
    output logic              illegal
);

    logic [DATA_W:0] res;

    generate
        if (USE_GRAY != 0) begin : g_gray
            assign res = decode_gray(code);
        end else begin : g_pow2
            assign res = decode_pow2(code);
        end
    endgenerate

    assign data    = res[DATA_W:1];
    assign illegal = res[0];

endmodule

// File: rtl/code_decoder.sv
// Streaming codeword decoder with one output register, illegal-word
// accounting and a sticky alarm on runs of illegal codewords.
module code_decoder
    import code_pkg::*;
#(
    parameter int USE_GRAY     = 0,
    parameter int ALARM_THRESH = 4,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              alarm,
    input  logic              alarm_clr
);

    localparam logic [3:0] THRESH = 4'(ALARM_THRESH);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        consec;
    logic [3:0]        consec_nx;
    logic [DATA_W-1:0] dec_data;
    logic              dec_illegal;
    logic              accept;

    code_decode_lut #(
        .USE_GRAY (USE_GRAY)
    ) u_lut (
        .code    (in_code),
        .data    (dec_data),
        .illegal (dec_illegal)
    );

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign alarm    = (state == ALARM);

    always_comb begin
        state_nx  = state;
        consec_nx = consec;
        case (state)
            RUN: begin
                if (accept) begin
                    if (dec_illegal) begin
                        consec_nx = consec + 4'd1;
                        if (consec_nx == THRESH) begin
                            state_nx = ALARM;
                        end
                    end else begin
                        consec_nx = 4'd0;
                    end
                end
            end
            ALARM: begin
                if (alarm_clr) begin
                    state_nx  = RUN;
                    consec_nx = 4'd0;
                end
            end
            default: begin
                state_nx  = RUN;
                consec_nx = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            consec <= 4'd0;
        end else begin
            state  <= state_nx;
            consec <= consec_nx;
        end
    end

    // Output register: a new accept wins over a same-cycle drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= dec_illegal ? '0 : dec_data;
            out_err   <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (accept && dec_illegal && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
